simd_host_loader: RTL and testbench

//  Upstream host-interface stage for the SIMD unit. It receives commands from the Pico as a
//  4-bit nibble bus with a strobe that is asynchronous to clk. It assembles the nibbles into

---
 rtl/simd_host_loader.sv | 216 +++++++++++++++++++++
 tb/tb_simd_host_loader.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/simd_host_loader.sv
// rtl/simd_host_loader.sv - Pico nibble-bus host loader: byte assembly, payload buffer, SIMD burst and send timing
module simd_host_loader #(
    parameter int NUM_BYTES    = 32,
    parameter int SEND_CYCLES  = 16,
    parameter int SETUP_CYCLES = 3,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] pico_nib,
    input  logic       pico_strb,
    output logic       pico_busy,
    output logic       err,
    output logic       load,
    output logic [7:0] simd_data,
    output logic [3:0] mode,
    output logic       dtype,
    output logic       send
);

    localparam int CNT_MAX = (NUM_BYTES > SEND_CYCLES) ? NUM_BYTES : SEND_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PAYLOAD,
        S_BURST,
        S_SETUP,
        S_SEND
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] strb_sync;
    logic [3:0]             nib_sync [SYNC_STAGES];
    logic                   strb_prev;
    logic                   strb_edge;
    logic                   phase_lo;
    logic [3:0]             hi_nib;
    logic [7:0]             byte_q;
    logic                   byte_valid;
    logic [IDX_W-1:0]       idx;
    logic [CNT_W-1:0]       cnt;
    logic [7:0]             payload_mem [NUM_BYTES];
    logic [1:0]             opcode;
    logic                   hdr_load;
    logic                   hdr_run;

    // Nibble and strobe both travel through the same synchronizer depth so they stay aligned
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strb_sync <= '0;
            strb_prev <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                nib_sync[i] <= 4'h0;
            end
        end else begin
            strb_sync[0] <= pico_strb;
            nib_sync[0]  <= pico_nib;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                strb_sync[i] <= strb_sync[i-1];
                nib_sync[i]  <= nib_sync[i-1];
            end
            strb_prev <= strb_sync[SYNC_STAGES-1];
        end
    end

    assign strb_edge = strb_sync[SYNC_STAGES-1] & ~strb_prev;
    assign pico_busy = (state == S_BURST) || (state == S_SETUP) || (state == S_SEND);
    assign opcode    = byte_q[7:6];
    assign hdr_load  = byte_valid && (state == S_IDLE) && (opcode == 2'b01);
    assign hdr_run   = byte_valid && (state == S_IDLE) && (opcode == 2'b10);

    // Nibble pairing: hi nibble first, byte_valid pulses for one cycle on the lo nibble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_lo   <= 1'b0;
            hi_nib     <= 4'h0;
            byte_q     <= 8'h00;
            byte_valid <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            if (strb_edge && !pico_busy) begin
                if (!phase_lo) begin
                    hi_nib   <= nib_sync[SYNC_STAGES-1];
                    phase_lo <= 1'b1;
                end else begin
                    byte_q     <= {hi_nib, nib_sync[SYNC_STAGES-1]};
                    byte_valid <= 1'b1;
                    phase_lo   <= 1'b0;
                end
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (hdr_load) begin
                    state_next = S_PAYLOAD;
                end else if (hdr_run) begin
                    state_next = S_SETUP;
                end
            end
            S_PAYLOAD: begin
                if (byte_valid && (idx == IDX_W'(NUM_BYTES - 1))) begin
                    state_next = S_BURST;
                end
            end
            S_BURST: begin
                if (cnt == CNT_W'(NUM_BYTES)) begin
                    state_next = S_IDLE;
                end
            end
            S_SETUP: begin
                if (cnt == CNT_W'(SETUP_CYCLES - 1)) begin
                    state_next = S_SEND;
                end
            end
            S_SEND: begin
                if (cnt == CNT_W'(SEND_CYCLES)) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Payload storage; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if ((state == S_PAYLOAD) && byte_valid) begin
            payload_mem[idx] <= byte_q;
        end
    end

    // Registered outputs, byte index and window counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            cnt       <= '0;
            load      <= 1'b0;
            simd_data <= 8'h00;
            send      <= 1'b0;
            mode      <= 4'h0;
            dtype     <= 1'b1;
            err       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (byte_valid) begin
                        err <= ~(hdr_load | hdr_run);
                    end
                    if (hdr_load) begin
                        idx <= '0;
                    end
                    if (hdr_run) begin
                        mode  <= byte_q[3:0];
                        dtype <= byte_q[4];
                        cnt   <= '0;
                    end
                end
                S_PAYLOAD: begin
                    if (byte_valid) begin
                        idx <= idx + 1'b1;
                    end
                    if (state_next == S_BURST) begin
                        load      <= 1'b1;
                        simd_data <= payload_mem[0];
                        cnt       <= CNT_W'(1);
                    end
                end
                S_BURST: begin
                    if (state_next == S_IDLE) begin
                        load <= 1'b0;
                    end else begin
                        simd_data <= payload_mem[cnt[IDX_W-1:0]];
                        cnt       <= cnt + 1'b1;
                    end
                end
                S_SETUP: begin
                    if (state_next == S_SEND) begin
                        send <= 1'b1;
                        cnt  <= CNT_W'(1);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_SEND: begin
                    if (state_next == S_IDLE) begin
                        send <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
            // A strobe while busy is dropped but flagged
            if (strb_edge && pico_busy) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_simd_host_loader.sv
// tb/tb_simd_host_loader.sv - randomized self-checking bench for simd_host_loader
module tb_simd_host_loader;

    localparam int NB     = 32;
    localparam int SENDC  = 16;
    localparam int SETUPC = 3;
    localparam int SYNC   = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] pico_nib = 4'h0;
    logic       pico_strb = 1'b0;
    logic       pico_busy, err, load, dtype, send;
    logic [7:0] simd_data;
    logic [3:0] mode;

    int vectors = 0;
    int miscompares = 0;

    simd_host_loader #(
        .NUM_BYTES(NB), .SEND_CYCLES(SENDC), .SETUP_CYCLES(SETUPC), .SYNC_STAGES(SYNC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pico_nib(pico_nib), .pico_strb(pico_strb),
        .pico_busy(pico_busy), .err(err), .load(load), .simd_data(simd_data),
        .mode(mode), .dtype(dtype), .send(send)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int cyc_at_strb = 0;
    always @(posedge clk) cyc++;

    // Observed activity, collected away from the active edge
    logic [7:0] load_q[$];
    logic [3:0] send_modes[$];
    int load_runs[$], send_runs[$], setup_q[$], lat_q[$];
    int load_run = 0, send_run = 0, setup_run = 0, busy_gaps = 0;
    logic load_prev = 1'b0;

    always @(negedge clk) begin
        if (load && !load_prev) lat_q.push_back(cyc - cyc_at_strb);
        load_prev = load;
        if (load) begin
            load_q.push_back(simd_data);
            load_run++;
        end else if (load_run != 0) begin
            load_runs.push_back(load_run);
            load_run = 0;
        end
        if (pico_busy && !send && !load) setup_run++;
        if (send) begin
            if (send_run == 0) begin
                setup_q.push_back(setup_run);
                send_modes.push_back(mode);
            end
            send_run++;
            if (!pico_busy) busy_gaps++;
        end else if (send_run != 0) begin
            send_runs.push_back(send_run);
            send_run = 0;
        end
        if (!pico_busy) setup_run = 0;
    end

    // Reference model state
    logic [3:0] m_mode = 4'h0;
    logic       m_dtype = 1'b1;
    logic [7:0] m_buf [NB];

    task automatic clear_mon();
        load_q.delete(); send_modes.delete(); load_runs.delete();
        send_runs.delete(); setup_q.delete(); lat_q.delete();
    endtask

    task automatic send_nib(input logic [3:0] n);
        @(posedge clk); #2 pico_nib = n;
        @(posedge clk); #6 pico_strb = 1'b1;
        cyc_at_strb = cyc;
        repeat ($urandom_range(3, 5)) @(posedge clk);
        #6 pico_strb = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_nib(b[7:4]);
        send_nib(b[3:0]);
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (!pico_busy) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        send_nib(4'hA);
        send_nib(4'h5);
        @(posedge clk); #1;
        vectors++; if (load !== 1'b0) begin miscompares++; $display("FAIL reset_load: got %b expected 0", load); end
        vectors++; if (send !== 1'b0) begin miscompares++; $display("FAIL reset_send: got %b expected 0", send); end
        vectors++; if (pico_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", pico_busy); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b expected 0", err); end
        vectors++; if (dtype !== 1'b1) begin miscompares++; $display("FAIL reset_dtype: got %b expected 1", dtype); end
        vectors++; if (mode !== 4'h0) begin miscompares++; $display("FAIL reset_mode: got %h expected 0", mode); end
        vectors++; if (simd_data !== 8'h00) begin miscompares++; $display("FAIL reset_data: got %h expected 00", simd_data); end
        #2 rst_n = 1'b1;
        m_mode = 4'h0;
        m_dtype = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_load(input bit spec_pattern);
        bit ok;
        for (int i = 0; i < NB; i++) m_buf[i] = 8'($urandom);
        if (spec_pattern) begin
            m_buf[0] = 8'hA1; m_buf[1] = 8'h13; m_buf[NB-1] = 8'h57;
        end
        clear_mon();
        send_byte(8'h40);
        for (int i = 0; i < NB; i++) send_byte(m_buf[i]);
        wait_idle(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL load_timeout: busy never cleared"); end
        vectors++;
        if (load_runs.size() != 1 || load_runs[0] != NB) begin
            miscompares++;
            $display("FAIL load_len: got %0d runs first %0d expected 1 run of %0d", load_runs.size(), load_runs[0], NB);
        end
        for (int i = 0; i < NB; i++) begin
            vectors++;
            if (load_q[i] !== m_buf[i]) begin
                miscompares++;
                $display("FAIL load_byte[%0d]: got %h expected %h", i, load_q[i], m_buf[i]);
            end
        end
        vectors++;
        if (lat_q.size() != 1 || lat_q[0] != SYNC + 2) begin
            miscompares++;
            $display("FAIL load_latency: got %0d clks expected %0d", lat_q[0], SYNC + 2);
        end
        vectors++; if (mode !== m_mode) begin miscompares++; $display("FAIL load_mode: got %h expected %h", mode, m_mode); end
        vectors++; if (dtype !== m_dtype) begin miscompares++; $display("FAIL load_dtype: got %b expected %b", dtype, m_dtype); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL load_err: got %b expected 0", err); end
        vectors++; if (simd_data !== m_buf[NB-1]) begin miscompares++; $display("FAIL load_hold: got %h expected %h", simd_data, m_buf[NB-1]); end
    endtask

    task automatic test_run(input logic [7:0] hdr);
        bit ok;
        int gaps0;
        m_mode = hdr[3:0];
        m_dtype = hdr[4];
        clear_mon();
        gaps0 = busy_gaps;
        send_byte(hdr);
        wait_idle(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL run_timeout: busy never cleared hdr %h", hdr); end
        vectors++;
        if (send_runs.size() != 1 || send_runs[0] != SENDC) begin
            miscompares++;
            $display("FAIL run_send_len: got %0d windows first %0d expected 1 of %0d", send_runs.size(), send_runs[0], SENDC);
        end
        vectors++; if (setup_q[0] != SETUPC) begin miscompares++; $display("FAIL run_setup: got %0d expected %0d", setup_q[0], SETUPC); end
        vectors++; if (send_modes[0] !== hdr[3:0]) begin miscompares++; $display("FAIL run_window_mode: got %h expected %h", send_modes[0], hdr[3:0]); end
        vectors++; if (busy_gaps != gaps0) begin miscompares++; $display("FAIL run_busy: got %0d unbusy send cycles expected 0", busy_gaps - gaps0); end
        vectors++; if (mode !== m_mode) begin miscompares++; $display("FAIL run_mode: got %h expected %h", mode, m_mode); end
        vectors++; if (dtype !== m_dtype) begin miscompares++; $display("FAIL run_dtype: got %b expected %b", dtype, m_dtype); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL run_err: got %b expected 0", err); end
        vectors++; if (load_q.size() != 0) begin miscompares++; $display("FAIL run_no_load: got %0d load cycles expected 0", load_q.size()); end
    endtask

    task automatic test_errors();
        bit ok;
        bit seen;
        logic [7:0] hdr;
        clear_mon();
        send_byte(8'hC5);
        repeat (4) @(posedge clk); #1;
        vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL bad_op_err: got %b expected 1", err); end
        vectors++; if (pico_busy !== 1'b0) begin miscompares++; $display("FAIL bad_op_busy: got %b expected 0", pico_busy); end
        vectors++; if (mode !== m_mode) begin miscompares++; $display("FAIL bad_op_mode: got %h expected %h", mode, m_mode); end
        vectors++; if (send_runs.size() != 0 || load_q.size() != 0) begin miscompares++; $display("FAIL bad_op_idle: got %0d sends %0d loads expected 0", send_runs.size(), load_q.size()); end

        hdr = {4'h9, 4'($urandom)};
        m_mode = hdr[3:0];
        m_dtype = hdr[4];
        send_byte(hdr);
        #1;
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL hdr_clears_err: got %b expected 0", err); end
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (send) begin seen = 1'b1; break; end
            @(posedge clk); #1;
        end
        vectors++; if (!seen) begin miscompares++; $display("FAIL send_timeout: send never rose"); end
        send_nib(4'($urandom));
        #1;
        vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL busy_strobe_err: got %b expected 1", err); end
        wait_idle(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL err_run_timeout: busy never cleared"); end
        vectors++;
        if (send_runs.size() != 1 || send_runs[0] != SENDC) begin
            miscompares++;
            $display("FAIL err_send_len: got %0d windows first %0d expected 1 of %0d", send_runs.size(), send_runs[0], SENDC);
        end
        vectors++; if (mode !== m_mode) begin miscompares++; $display("FAIL err_run_mode: got %h expected %h", mode, m_mode); end
        test_run(8'h80);
    endtask

    task automatic test_reset_mid_burst();
        bit seen;
        for (int i = 0; i < NB; i++) m_buf[i] = 8'($urandom);
        clear_mon();
        send_byte(8'h40);
        for (int i = 0; i < NB - 1; i++) send_byte(m_buf[i]);
        send_nib(m_buf[NB-1][7:4]);
        @(posedge clk); #2 pico_nib = m_buf[NB-1][3:0];
        @(posedge clk); #6 pico_strb = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (load) begin seen = 1'b1; break; end
        end
        vectors++; if (!seen) begin miscompares++; $display("FAIL midburst_timeout: load never rose"); end
        repeat (10) @(posedge clk);
        #1;
        vectors++; if (simd_data !== m_buf[10]) begin miscompares++; $display("FAIL midburst_byte10: got %h expected %h", simd_data, m_buf[10]); end
        #1 rst_n = 1'b0;
        #1;
        vectors++; if (load !== 1'b0) begin miscompares++; $display("FAIL async_load_drop: got %b expected 0", load); end
        vectors++; if (pico_busy !== 1'b0) begin miscompares++; $display("FAIL async_busy_drop: got %b expected 0", pico_busy); end
        pico_strb = 1'b0;
        m_mode = 4'h0;
        m_dtype = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(posedge clk); #1;
        vectors++; if (dtype !== m_dtype || mode !== m_mode) begin miscompares++; $display("FAIL midburst_reset_vals: got mode %h dtype %b expected %h %b", mode, dtype, m_mode, m_dtype); end
        test_run(8'h82);
    endtask

    task automatic test_back_to_back();
        test_load(1'b0);
        for (int m = 0; m < 4; m++) test_run({3'b100, 1'($urandom), 4'(m)});
        test_load(1'b0);
    endtask

    initial begin
        test_reset();
        test_load(1'b1);
        test_run(8'h91);
        test_errors();
        test_reset_mid_burst();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
